// File: rtl/activation_scheduler_if.sv
// activation_scheduler_if: request, sigmoid-unit and result signals of the activation scheduler.
// slave is the scheduler side; master is the side driving requests and the sigmoid result.

interface activation_scheduler_if #(
    parameter int unsigned NEURONS    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_W       = $clog2(NEURONS)
);
    logic [NEURONS-1:0]            req;
    logic [NEURONS*DATA_WIDTH-1:0] req_data;
    logic [NEURONS-1:0]            grant;
    logic [DATA_WIDTH-1:0]         act_in;
    logic                          act_enable;
    logic [DATA_WIDTH-1:0]         act_out;
    logic                          act_valid;
    logic [DATA_WIDTH-1:0]         res_data;
    logic [ID_W-1:0]               res_id;
    logic                          res_valid;
    logic                          layer_done;
    logic                          busy;
    logic                          err;

    modport master (
        output req, req_data, act_out, act_valid,
        input  grant, act_in, act_enable, res_data, res_id, res_valid, layer_done, busy, err
    );

    modport slave (
        input  req, req_data, act_out, act_valid,
        output grant, act_in, act_enable, res_data, res_id, res_valid, layer_done, busy, err
    );
endinterface

// File: rtl/activation_scheduler.sv
// activation_scheduler: round-robin arbiter that serialises neuron pre-activation sums through
// one shared sigmoid unit and returns tagged results.
// Optional WAIT watchdog: define ACT_SCHED_TIMEOUT_EN.

module activation_scheduler #(
    parameter int unsigned NEURONS    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_W       = $clog2(NEURONS)
) (
    input logic                   clk,
    input logic                   rst_n,
    activation_scheduler_if.slave sched_io
);
    localparam int unsigned CntW = ID_W + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StWrite} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] op_q, op_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [ID_W-1:0]       res_id_q, res_id_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  win_found;
    logic [ID_W-1:0]       win_idx;
    logic [NEURONS-1:0]    grant;
    logic                  last_res;
`ifdef ACT_SCHED_TIMEOUT_EN
    logic                  err_q, err_d;
    logic [2:0]            wdog_q, wdog_d;
`endif

    assign last_res = (cnt_q == CntW'(NEURONS - 1));

    // Round-robin search: first requester at or after the pointer, wrapping past NEURONS-1.
    always_comb begin
        int unsigned     cand;
        logic [ID_W-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NEURONS; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NEURONS) begin
                cand = cand - NEURONS;
            end
            cand_idx = ID_W'(cand);
            if (!win_found && sched_io.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and grant logic for the IDLE/ISSUE/WAIT/WRITE sequence.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        grant      = '0;
`ifdef ACT_SCHED_TIMEOUT_EN
        err_d      = err_q;
        wdog_d     = wdog_q;
`endif
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant[win_idx] = 1'b1;
                    op_d           = sched_io.req_data[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
                    id_d           = win_idx;
                    ptr_d          = (win_idx == ID_W'(NEURONS - 1)) ? '0 : win_idx + 1'b1;
                    state_d        = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
`ifdef ACT_SCHED_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            StWait: begin
                if (sched_io.act_valid) begin
                    res_data_d = sched_io.act_out;
                    res_id_d   = id_q;
                    state_d    = StWrite;
                end
`ifdef ACT_SCHED_TIMEOUT_EN
                // Eighth silent WAIT cycle: give up and report a zero result for this neuron.
                else if (wdog_q == 3'd7) begin
                    res_data_d = '0;
                    res_id_d   = id_q;
                    err_d      = 1'b1;
                    state_d    = StWrite;
                end else begin
                    wdog_d = wdog_q + 3'd1;
                end
`endif
            end
            StWrite: begin
                cnt_d   = last_res ? '0 : cnt_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= '0;
            id_q       <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

`ifdef ACT_SCHED_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            wdog_q <= '0;
        end else begin
            err_q  <= err_d;
            wdog_q <= wdog_d;
        end
    end
    assign sched_io.err = err_q;
`else
    assign sched_io.err = 1'b0;
`endif

    // grant is combinational from req, so it is also forced low while reset is held.
    assign sched_io.grant      = rst_n ? grant : '0;
    assign sched_io.act_in     = op_q;
    assign sched_io.act_enable = (state_q == StIssue);
    assign sched_io.res_valid  = (state_q == StWrite);
    assign sched_io.res_data   = res_data_q;
    assign sched_io.res_id     = res_id_q;
    assign sched_io.layer_done = (state_q == StWrite) && last_res;
    assign sched_io.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_activation_scheduler.sv
// tb_activation_scheduler: randomized transactions against a transaction-level reference model.

module tb_activation_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    activation_scheduler_if #(.NEURONS(N), .DATA_WIDTH(DW), .ID_W(IW)) sif ();

    activation_scheduler #(.NEURONS(N), .DATA_WIDTH(DW), .ID_W(IW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_io (sif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: next search start, results in current layer, sticky error,
    // last reported result.
    int            m_ptr = 0;
    int            m_cnt = 0;
    logic          m_err = 1'b0;
    logic [DW-1:0] m_res = '0;
    int            m_id  = 0;
    logic [N*DW-1:0] stim_data;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_cnt = 0;
        m_err = 1'b0;
        m_res = '0;
        m_id  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"}, 32'(sif.grant), 0);
        check_eq({tag, "_act_enable"}, 32'(sif.act_enable), 0);
        check_eq({tag, "_act_in"}, 32'(sif.act_in), 0);
        check_eq({tag, "_res_valid"}, 32'(sif.res_valid), 0);
        check_eq({tag, "_res_data"}, 32'(sif.res_data), 0);
        check_eq({tag, "_res_id"}, 32'(sif.res_id), 0);
        check_eq({tag, "_layer_done"}, 32'(sif.layer_done), 0);
        check_eq({tag, "_busy"}, 32'(sif.busy), 0);
        check_eq({tag, "_err"}, 32'(sif.err), 0);
    endtask

    // Called at posedge+1 of a cycle the model expects to be IDLE; returns at the same point.
    task automatic txn(input logic [N-1:0] vec, input logic [N-1:0] busy_req, input int delay,
                       input logic [DW-1:0] aout);
        int            w;
        logic [DW-1:0] op;
        logic          exp_done;
        sif.req_data  = stim_data;
        sif.req       = vec;
        sif.act_valid = (vec == '0) ? 1'b1 : 1'($urandom);
        sif.act_out   = DW'($urandom);
        w = rr_pick(vec, m_ptr);
        @(negedge clk);
        check_eq("idle_busy", 32'(sif.busy), 0);
        check_eq("idle_res_valid", 32'(sif.res_valid), 0);
        check_eq("idle_res_data_hold", 32'(sif.res_data), 32'(m_res));
        check_eq("idle_res_id_hold", 32'(sif.res_id), 32'(m_id));
        if (w < 0) begin
            check_eq("grant_none", 32'(sif.grant), 0);
            @(posedge clk); #1;
            sif.act_valid = 1'b0;
            @(negedge clk);
            check_eq("spurious_no_res", 32'(sif.res_valid), 0);
            check_eq("spurious_busy", 32'(sif.busy), 0);
            @(posedge clk); #1;
            return;
        end
        check_eq("grant", 32'(sif.grant), 32'(1) << w);
        op    = stim_data[w*DW +: DW];
        m_ptr = (w + 1) % N;
        // ISSUE, with a spurious act_valid that must be ignored.
        @(posedge clk); #1;
        sif.req       = busy_req;
        sif.act_valid = 1'($urandom);
        sif.act_out   = DW'($urandom);
        @(negedge clk);
        check_eq("issue_enable", 32'(sif.act_enable), 1);
        check_eq("issue_act_in", 32'(sif.act_in), 32'(op));
        check_eq("issue_grant", 32'(sif.grant), 0);
        check_eq("issue_busy", 32'(sif.busy), 1);
        check_eq("issue_res_valid", 32'(sif.res_valid), 0);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            sif.act_valid = 1'b0;
            sif.act_out   = DW'($urandom);
            @(negedge clk);
            check_eq("wait_enable", 32'(sif.act_enable), 0);
            check_eq("wait_act_in", 32'(sif.act_in), 32'(op));
            check_eq("wait_res_valid", 32'(sif.res_valid), 0);
            check_eq("wait_grant", 32'(sif.grant), 0);
        end
        @(posedge clk); #1;
        sif.act_valid = 1'b1;
        sif.act_out   = aout;
        @(negedge clk);
        check_eq("wait_last_res_valid", 32'(sif.res_valid), 0);
        check_eq("wait_last_busy", 32'(sif.busy), 1);
        m_cnt++;
        exp_done = (m_cnt == N);
        if (exp_done) m_cnt = 0;
        // WRITE, with another act_valid that must be ignored.
        @(posedge clk); #1;
        sif.act_valid = 1'($urandom);
        sif.act_out   = DW'($urandom);
        @(negedge clk);
        check_eq("write_res_valid", 32'(sif.res_valid), 1);
        check_eq("write_res_data", 32'(sif.res_data), 32'(aout));
        check_eq("write_res_id", 32'(sif.res_id), 32'(w));
        check_eq("write_layer_done", 32'(sif.layer_done), 32'(exp_done));
        check_eq("write_err", 32'(sif.err), 32'(m_err));
        check_eq("write_grant", 32'(sif.grant), 0);
        m_res = aout;
        m_id  = w;
        @(posedge clk); #1;
        sif.act_valid = 1'b0;
        sif.req       = '0;
    endtask

`ifdef ACT_SCHED_TIMEOUT_EN
    task automatic txn_timeout(input logic [N-1:0] vec);
        int   w;
        logic exp_done;
        stim_data     = (N*DW)'($urandom);
        sif.req_data  = stim_data;
        sif.req       = vec;
        sif.act_valid = 1'b0;
        w = rr_pick(vec, m_ptr);
        @(negedge clk);
        check_eq("to_grant", 32'(sif.grant), 32'(1) << w);
        m_ptr = (w + 1) % N;
        @(posedge clk); #1;
        sif.req = '0;
        @(negedge clk);
        check_eq("to_issue", 32'(sif.act_enable), 1);
        repeat (8) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("to_wait_res_valid", 32'(sif.res_valid), 0);
            check_eq("to_wait_err", 32'(sif.err), 32'(m_err));
        end
        m_err = 1'b1;
        m_cnt++;
        exp_done = (m_cnt == N);
        if (exp_done) m_cnt = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("to_res_valid", 32'(sif.res_valid), 1);
        check_eq("to_res_data", 32'(sif.res_data), 0);
        check_eq("to_res_id", 32'(sif.res_id), 32'(w));
        check_eq("to_err", 32'(sif.err), 1);
        check_eq("to_layer_done", 32'(sif.layer_done), 32'(exp_done));
        m_res = '0;
        m_id  = w;
        @(posedge clk); #1;
    endtask
`endif

    task automatic do_reset();
        sif.req       = '0;
        sif.act_valid = 1'b0;
        rst_n         = 1'b0;
        #1;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    // Reset asserted asynchronously in WAIT while a request is still raised.
    task automatic reset_mid_wait();
        int w;
        stim_data     = (N*DW)'($urandom);
        sif.req_data  = stim_data;
        sif.req       = 4'b0100;
        sif.act_valid = 1'b0;
        w = rr_pick(sif.req, m_ptr);
        @(negedge clk);
        check_eq("rmw_grant", 32'(sif.grant), 32'(1) << w);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rmw");
        @(negedge clk);
        sif.req = '0;
        rst_n   = 1'b1;
        model_reset();
        @(posedge clk); #1;
        sif.act_valid = 1'b1;
        sif.act_out   = 8'h5A;
        @(negedge clk);
        check_eq("rmw_late_valid_res", 32'(sif.res_valid), 0);
        check_eq("rmw_late_valid_busy", 32'(sif.busy), 0);
        @(posedge clk); #1;
        sif.act_valid = 1'b0;
        @(negedge clk);
        check_eq("rmw_after_res", 32'(sif.res_valid), 0);
        check_eq("rmw_after_busy", 32'(sif.busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [N-1:0] vec;
        sif.req       = '0;
        sif.req_data  = '0;
        sif.act_out   = '0;
        sif.act_valid = 1'b0;
        stim_data     = '0;
        model_reset();
        #12;
        check_all_zero("init");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single request, sigmoid answers in the first WAIT cycle.
        stim_data = (N*DW)'($urandom);
        stim_data[7:0] = 8'h7A;
        txn(4'b0001, 4'b0000, 0, 8'h00);

        // All neurons requesting continuously: one full layer.
        do_reset();
        for (int i = 0; i < N; i++) begin
            stim_data = (N*DW)'($urandom);
            txn(4'b1111, 4'b1111, 0, DW'($urandom));
        end

        // Pointer wrap: serve neuron 2, then 0101 picks 0 before 2.
        stim_data = (N*DW)'($urandom);
        txn(4'b0100, 4'b0000, 1, DW'($urandom));
        stim_data = (N*DW)'($urandom);
        txn(4'b0101, 4'b0101, 0, DW'($urandom));
        stim_data = (N*DW)'($urandom);
        txn(4'b0101, 4'b0000, 2, DW'($urandom));

        // Spurious act_valid while idle with no requests.
        txn(4'b0000, 4'b0000, 0, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            vec = N'($urandom);
            if ($urandom_range(0, 7) == 0) vec = '0;
            stim_data = (N*DW)'($urandom);
            txn(vec, N'($urandom), int'($urandom_range(0, 5)), DW'($urandom));
        end

`ifdef ACT_SCHED_TIMEOUT_EN
        txn_timeout(4'b0010);
        stim_data = (N*DW)'($urandom);
        txn(4'b1000, 4'b0000, 1, DW'($urandom));
`endif

        reset_mid_wait();
        stim_data = (N*DW)'($urandom);
        txn(4'b0110, 4'b0000, 0, DW'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
